// File: rtl/tape_reader_pkg.sv
// Shared definitions for the tape reader: character width and reader FSM encoding.
package tape_reader_pkg;

  localparam int TAPE_CHAR_W = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DELAY     = 2'd1,
    STROBE    = 2'd2,
    WAIT_DROP = 2'd3
  } tape_state_e;

endpackage

// File: rtl/tape_reader_if.sv
// Host load channel plus core input handshake for the tape reader.
// master = host/core side, slave = the reader itself.
interface tape_reader_if
  import tape_reader_pkg::*;
#(
  parameter int DEPTH = 16
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   load_valid;
  logic                   load_ready;
  logic [TAPE_CHAR_W-1:0] load_data;
  logic                   tape_clear;
  logic                   dev_input_rdy;
  logic                   dev_input_val;
  logic [TAPE_CHAR_W-1:0] dev_input_data;
  logic [CNT_W-1:0]       tape_count;
  logic                   tape_empty;

  modport master (
    output load_valid, load_data, tape_clear, dev_input_rdy,
    input  load_ready, dev_input_val, dev_input_data, tape_count, tape_empty
  );

  modport slave (
    input  load_valid, load_data, tape_clear, dev_input_rdy,
    output load_ready, dev_input_val, dev_input_data, tape_count, tape_empty
  );

endinterface

// File: rtl/tape_fifo.sv
// Circular character buffer with wrap-around pointers; clear has priority over push/pop.
// A simultaneous push and pop leaves the count unchanged.
module tape_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/tape_reader.sv
// Tape reader: buffers host characters and strobes one per dev_input_rdy after CHAR_DELAY cycles.
// Define TAPE_READER_COUNT_EN to add the 16-bit delivered_count output.
module tape_reader
  import tape_reader_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int CHAR_DELAY = 8
) (
  input  logic               clk,
  input  logic               resetn,
  tape_reader_if.slave       bus
`ifdef TAPE_READER_COUNT_EN
  ,
  output logic [15:0]        delivered_count
`endif
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int STEP_W = (CHAR_DELAY > 1) ? $clog2(CHAR_DELAY) : 1;
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(CHAR_DELAY - 1);

  tape_state_e            state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [TAPE_CHAR_W-1:0] data_q, data_d;
  logic [TAPE_CHAR_W-1:0] head;
  logic [CNT_W-1:0]       count;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;

  assign push = bus.load_valid && !fifo_full && !bus.tape_clear;
  assign pop  = (state_q == STROBE);

  tape_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TAPE_CHAR_W)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push),
    .push_data_i (bus.load_data),
    .pop_i       (pop),
    .clear_i     (bus.tape_clear),
    .head_o      (head),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Status comes straight from registered state, so a same-cycle pop never raises load_ready.
  assign bus.load_ready     = !fifo_full;
  assign bus.tape_count     = count;
  assign bus.tape_empty     = fifo_empty;
  assign bus.dev_input_val  = (state_q == STROBE);
  assign bus.dev_input_data = data_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dev_input_rdy && !fifo_empty) begin
          data_d  = head;
          step_d  = STEP_LOAD;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (step_q != '0) step_d = step_q - STEP_W'(1);
        if (!bus.dev_input_rdy)  state_d = IDLE;
        else if (step_q == '0)   state_d = STROBE;
      end
      STROBE:    state_d = WAIT_DROP;
      WAIT_DROP: if (!bus.dev_input_rdy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // A flush aborts any delivery but leaves the presented character in place.
    if (bus.tape_clear) begin
      state_d = IDLE;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      step_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      data_q  <= data_d;
    end
  end

`ifdef TAPE_READER_COUNT_EN
  logic [15:0] delivered_q, delivered_d;

  assign delivered_d     = (pop && !bus.tape_clear) ? delivered_q + 16'd1 : delivered_q;
  assign delivered_count = delivered_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) delivered_q <= '0;
    else         delivered_q <= delivered_d;
  end
`endif

endmodule

// File: tb/tb_tape_reader.sv
// Directed bench for tape_reader (DEPTH=16, CHAR_DELAY=8) with immediate-assertion checks.
module tb_tape_reader;
  import tape_reader_pkg::*;

  localparam int DEPTH      = 16;
  localparam int CHAR_DELAY = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tape_reader_if #(.DEPTH(DEPTH)) bus ();

`ifdef TAPE_READER_COUNT_EN
  logic [15:0] delivered_count;
`endif

  tape_reader #(
    .DEPTH      (DEPTH),
    .CHAR_DELAY (CHAR_DELAY)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef TAPE_READER_COUNT_EN
    ,
    .delivered_count (delivered_count)
`endif
  );

  int checks     = 0;
  int passed     = 0;
  int failed     = 0;
  int strobe_cnt = 0;

  logic [4:0] fill_vals [16] = '{5'h03, 5'h0A, 5'h11, 5'h18, 5'h1F, 5'h06, 5'h0D, 5'h14,
                                 5'h1B, 5'h02, 5'h09, 5'h10, 5'h17, 5'h1E, 5'h05, 5'h0C};

  always @(negedge clk) begin
    if (resetn && bus.dev_input_val === 1'b1) strobe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_char(input logic [4:0] d);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    step();
    bus.load_valid = 1'b0;
  endtask

  // Raise rdy and step until the strobe appears (bounded); leaves the bench in the strobe cycle.
  task automatic request(output int n);
    bus.dev_input_rdy = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.dev_input_val !== 1'b1 && n < 40);
  endtask

  task automatic release_rdy();
    bus.dev_input_rdy = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int snap;
    bus.load_valid    = 1'b0;
    bus.load_data     = '0;
    bus.tape_clear    = 1'b0;
    bus.dev_input_rdy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.tape_count), 0);
    check("rst_empty", 32'(bus.tape_empty), 1);
    check("rst_ready", 32'(bus.load_ready), 1);
    check("rst_val",   32'(bus.dev_input_val), 0);
    check("rst_data",  32'(bus.dev_input_data), 0);
`ifdef TAPE_READER_COUNT_EN
    check("rst_dcnt",  32'(delivered_count), 0);
`endif
    resetn = 1'b1;
    step();

    load_char(5'h1F);
    load_char(5'h00);
    load_char(5'h15);
    repeat (4) step();
    check("load_count",   32'(bus.tape_count), 3);
    check("load_empty",   32'(bus.tape_empty), 0);
    check("rdylow_strb",  32'(strobe_cnt), 0);
    check("rdylow_data",  32'(bus.dev_input_data), 0);

    request(n);
    check("lat1",         32'(n), 9);
    check("strobe1_data", 32'(bus.dev_input_data), 32'h1F);
    check("strobe1_cnt",  32'(bus.tape_count), 3);
    repeat (20) step();
    check("hold_strobes", 32'(strobe_cnt), 1);
    check("hold_count",   32'(bus.tape_count), 2);
    check("hold_val",     32'(bus.dev_input_val), 0);
    release_rdy();

    request(n);
    check("lat2",         32'(n), 9);
    check("strobe2_data", 32'(bus.dev_input_data), 32'h00);
    release_rdy();
    check("after2_count", 32'(bus.tape_count), 1);

    // Drop rdy four cycles into DELAY.
    bus.dev_input_rdy = 1'b1;
    repeat (4) step();
    bus.dev_input_rdy = 1'b0;
    step();
    check("abort_val",     32'(bus.dev_input_val), 0);
    repeat (3) step();
    check("abort_strobes", 32'(strobe_cnt), 2);
    check("abort_count",   32'(bus.tape_count), 1);
    check("abort_data",    32'(bus.dev_input_data), 32'h15);
    request(n);
    check("lat3",          32'(n), 9);
    check("strobe3_data",  32'(bus.dev_input_data), 32'h15);
    release_rdy();
    check("drain_count",   32'(bus.tape_count), 0);
    check("drain_empty",   32'(bus.tape_empty), 1);
`ifdef TAPE_READER_COUNT_EN
    check("dcnt_3",        32'(delivered_count), 3);
`endif

    // Fill to DEPTH, then pop at full and push+pop at 15, wrapping the pointers.
    for (int i = 0; i < 15; i++) load_char(fill_vals[i]);
    check("fill15_ready", 32'(bus.load_ready), 1);
    check("fill15_count", 32'(bus.tape_count), 15);
    load_char(fill_vals[15]);
    check("full_count",   32'(bus.tape_count), 16);
    check("full_ready",   32'(bus.load_ready), 0);
    load_char(5'h1D);
    check("full_hold",    32'(bus.tape_count), 16);

    request(n);
    check("lat_full",     32'(n), 9);
    check("full_data",    32'(bus.dev_input_data), 32'h03);
    check("strobe_ready", 32'(bus.load_ready), 0);
    bus.load_valid    = 1'b1;
    bus.load_data     = 5'h1D;
    bus.dev_input_rdy = 1'b0;
    step();
    bus.load_valid = 1'b0;
    check("pop_count",    32'(bus.tape_count), 15);
    check("pop_ready",    32'(bus.load_ready), 1);
    step();

    request(n);
    check("pp_data",      32'(bus.dev_input_data), 32'h0A);
    bus.load_valid    = 1'b1;
    bus.load_data     = 5'h19;
    bus.dev_input_rdy = 1'b0;
    step();
    bus.load_valid = 1'b0;
    check("pushpop_count", 32'(bus.tape_count), 15);
    step();

    for (int i = 2; i < 16; i++) begin
      request(n);
      check("wrap_lat",  32'(n), 9);
      check("wrap_data", 32'(bus.dev_input_data), 32'(fill_vals[i]));
      release_rdy();
    end
    request(n);
    check("wrap_last",  32'(bus.dev_input_data), 32'h19);
    release_rdy();
    check("wrap_count", 32'(bus.tape_count), 0);
`ifdef TAPE_READER_COUNT_EN
    check("dcnt_20",    32'(delivered_count), 20);
`endif

    // Clear with a coincident load during DELAY.
    load_char(5'h07);
    load_char(5'h08);
    bus.dev_input_rdy = 1'b1;
    repeat (3) step();
    snap = strobe_cnt;
    bus.tape_clear = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 5'h1C;
    step();
    bus.tape_clear = 1'b0;
    bus.load_valid = 1'b0;
    check("clr_count", 32'(bus.tape_count), 0);
    check("clr_empty", 32'(bus.tape_empty), 1);
    check("clr_val",   32'(bus.dev_input_val), 0);
    check("clr_data",  32'(bus.dev_input_data), 32'h07);
    repeat (12) step();
    check("clr_strobes",    32'(strobe_cnt), 32'(snap));
    check("clr_idle_count", 32'(bus.tape_count), 0);
    bus.dev_input_rdy = 1'b0;
    step();
    load_char(5'h0E);
    request(n);
    check("post_clr_lat",  32'(n), 9);
    check("post_clr_data", 32'(bus.dev_input_data), 32'h0E);
    release_rdy();
    check("post_clr_count", 32'(bus.tape_count), 0);
`ifdef TAPE_READER_COUNT_EN
    check("dcnt_21",        32'(delivered_count), 21);
`endif

    // Clear coincident with the strobe: strobe seen, pop discarded, not counted.
    load_char(5'h01);
    load_char(5'h02);
    snap = strobe_cnt;
    request(n);
    check("cs_data", 32'(bus.dev_input_data), 32'h01);
    bus.tape_clear    = 1'b1;
    bus.dev_input_rdy = 1'b0;
    step();
    bus.tape_clear = 1'b0;
    check("cs_count",   32'(bus.tape_count), 0);
    check("cs_val",     32'(bus.dev_input_val), 0);
    step();
    check("cs_strobes", 32'(strobe_cnt), 32'(snap + 1));
`ifdef TAPE_READER_COUNT_EN
    check("dcnt_cs",    32'(delivered_count), 21);
`endif

    // Reset mid-delivery.
    load_char(5'h03);
    bus.dev_input_rdy = 1'b1;
    repeat (3) step();
    snap   = strobe_cnt;
    resetn = 1'b0;
    #1;
    check("mrst_val",   32'(bus.dev_input_val), 0);
    check("mrst_count", 32'(bus.tape_count), 0);
    check("mrst_empty", 32'(bus.tape_empty), 1);
    check("mrst_ready", 32'(bus.load_ready), 1);
    check("mrst_data",  32'(bus.dev_input_data), 0);
`ifdef TAPE_READER_COUNT_EN
    check("mrst_dcnt",  32'(delivered_count), 0);
`endif
    repeat (5) step();
    resetn = 1'b1;
    repeat (12) step();
    check("mrst_strobes", 32'(strobe_cnt), 32'(snap));
    check("mrst_lost",    32'(bus.tape_count), 0);
    check("mrst_idle",    32'(bus.dev_input_val), 0);
    bus.dev_input_rdy = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
